rs_age_multi_cdb: RTL and testbench

//  Parametrised ALU reservation station: holds decoded ops until both operands arrive, then issues to the ALU.

---
 rtl/rs_age_multi_cdb_pkg.sv | 16 +
 rtl/rs_age_select.sv | 26 ++
 rtl/rs_age_multi_cdb.sv | 178 +++++++++++++++++
 tb/tb_rs_age_multi_cdb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_age_multi_cdb_pkg.sv
// rtl/rs_age_multi_cdb_pkg.sv - shared constants and default widths for the ALU reservation station
package rs_age_multi_cdb_pkg;

    localparam int DEF_RS_DEPTH  = 16;
    localparam int DEF_ROB_TAG_W = 4;
    localparam int DEF_OP_W      = 6;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_NUM_CDB   = 2;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [DEF_OP_W-1:0]      NOP          = '0;
    localparam logic [DEF_ROB_TAG_W-1:0] ZERO_TAG_ROB = '0;

endpackage

// File: rtl/rs_age_select.sv
// rtl/rs_age_select.sv - picks the oldest eligible entry from an age matrix
module rs_age_select #(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0]            eligible_i,
    input  logic [DEPTH-1:0][DEPTH-1:0] older_i,
    output logic [DEPTH-1:0]            grant_o,
    output logic                        found_o
);

    // An entry wins when it is older than every other eligible entry.
    always_comb begin
        grant_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant_o[i] = eligible_i[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && eligible_i[j] && !older_i[i][j]) begin
                    grant_o[i] = 1'b0;
                end
            end
        end
    end

    assign found_o = |eligible_i;

endmodule

// File: rtl/rs_age_multi_cdb.sv
// rtl/rs_age_multi_cdb.sv - ALU reservation station with multi-CDB wakeup and oldest-ready-first issue
module rs_age_multi_cdb
    import rs_age_multi_cdb_pkg::*;
#(
    parameter int RS_DEPTH  = DEF_RS_DEPTH,
    parameter int ROB_TAG_W = DEF_ROB_TAG_W,
    parameter int OP_W      = DEF_OP_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_CDB   = DEF_NUM_CDB,
    localparam int CNT_W    = $clog2(RS_DEPTH + 1),
    localparam int IDX_W    = $clog2(RS_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic                          in_fetcher_ce,
    input  logic [ROB_TAG_W-1:0]          in_decode_rob_tag,
    input  logic [OP_W-1:0]               in_decode_op,
    input  logic [DATA_W-1:0]             in_decode_value1,
    input  logic [DATA_W-1:0]             in_decode_value2,
    input  logic [ROB_TAG_W-1:0]          in_decode_tag1,
    input  logic [ROB_TAG_W-1:0]          in_decode_tag2,
    input  logic [DATA_W-1:0]             in_decode_imm,
    input  logic [DATA_W-1:0]             in_decode_pc,
    input  logic [NUM_CDB*ROB_TAG_W-1:0]  in_cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]     in_cdb_value,
    input  logic                          in_alu_ready,
    input  logic                          in_rob_misbranch,
    output logic                          out_fetcher_isidle,
    output logic [CNT_W-1:0]              out_rs_count,
    output logic [OP_W-1:0]               out_alu_op,
    output logic [DATA_W-1:0]             out_alu_value1,
    output logic [DATA_W-1:0]             out_alu_value2,
    output logic [DATA_W-1:0]             out_alu_imm,
    output logic [DATA_W-1:0]             out_alu_pc,
    output logic [ROB_TAG_W-1:0]          out_alu_rob_tag
);

    localparam logic [OP_W-1:0]      OP_NOP   = OP_W'(NOP);
    localparam logic [ROB_TAG_W-1:0] TAG_NONE = ROB_TAG_W'(ZERO_TAG_ROB);

    logic [RS_DEPTH-1:0]               valid_q;
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q;
    logic [OP_W-1:0]                   op_q  [RS_DEPTH];
    logic [DATA_W-1:0]                 v1_q  [RS_DEPTH];
    logic [DATA_W-1:0]                 v2_q  [RS_DEPTH];
    logic [ROB_TAG_W-1:0]              t1_q  [RS_DEPTH];
    logic [ROB_TAG_W-1:0]              t2_q  [RS_DEPTH];
    logic [DATA_W-1:0]                 imm_q [RS_DEPTH];
    logic [DATA_W-1:0]                 pc_q  [RS_DEPTH];
    logic [ROB_TAG_W-1:0]              rob_q [RS_DEPTH];
    logic [CNT_W-1:0]                  count_q;

    logic [OP_W-1:0]      alu_op_q;
    logic [DATA_W-1:0]    alu_v1_q, alu_v2_q, alu_imm_q, alu_pc_q;
    logic [ROB_TAG_W-1:0] alu_rob_q;

    logic [RS_DEPTH-1:0] eligible, grant;
    logic                found, has_free, do_issue, do_dispatch;
    logic [IDX_W-1:0]    issue_idx, alloc_idx;
    logic [DATA_W:0]     wk1 [RS_DEPTH];
    logic [DATA_W:0]     wk2 [RS_DEPTH];
    logic [DATA_W:0]     dk1, dk2;

    // Returns {hit, value}; scanning high to low lets the lowest channel win.
    function automatic logic [DATA_W:0] cdb_lookup(input logic [ROB_TAG_W-1:0] tag);
        logic [DATA_W:0] r;
        r = '0;
        if (tag != TAG_NONE) begin
            for (int k = NUM_CDB - 1; k >= 0; k--) begin
                if (in_cdb_tag[k*ROB_TAG_W +: ROB_TAG_W] == tag) begin
                    r = {1'b1, in_cdb_value[k*DATA_W +: DATA_W]};
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            eligible[i] = valid_q[i] && t1_q[i] == TAG_NONE && t2_q[i] == TAG_NONE;
            wk1[i]      = valid_q[i] ? cdb_lookup(t1_q[i]) : '0;
            wk2[i]      = valid_q[i] ? cdb_lookup(t2_q[i]) : '0;
        end
        dk1 = cdb_lookup(in_decode_tag1);
        dk2 = cdb_lookup(in_decode_tag2);
    end

    rs_age_select #(.DEPTH(RS_DEPTH)) u_age_select (
        .eligible_i (eligible),
        .older_i    (age_q),
        .grant_o    (grant),
        .found_o    (found)
    );

    always_comb begin
        issue_idx = '0;
        alloc_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (grant[i]) issue_idx = IDX_W'(i);
        end
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx = IDX_W'(i);
        end
    end

    // The slot freed by this cycle's issue is deliberately not counted as free.
    assign has_free    = ~&valid_q;
    assign do_issue    = in_alu_ready && found;
    assign do_dispatch = in_fetcher_ce && in_decode_rob_tag != TAG_NONE && has_free;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q   <= '0;
            age_q     <= '0;
            count_q   <= '0;
            alu_op_q  <= OP_NOP;
            alu_v1_q  <= '0;
            alu_v2_q  <= '0;
            alu_imm_q <= '0;
            alu_pc_q  <= '0;
            alu_rob_q <= '0;
        end else if (rdy) begin
            alu_op_q <= OP_NOP;
            if (in_rob_misbranch) begin
                valid_q <= '0;
                age_q   <= '0;
                count_q <= '0;
            end else begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (wk1[i][DATA_W]) begin
                        v1_q[i] <= wk1[i][DATA_W-1:0];
                        t1_q[i] <= TAG_NONE;
                    end
                    if (wk2[i][DATA_W]) begin
                        v2_q[i] <= wk2[i][DATA_W-1:0];
                        t2_q[i] <= TAG_NONE;
                    end
                end
                if (do_issue) begin
                    valid_q[issue_idx] <= 1'b0;
                    alu_op_q  <= op_q[issue_idx];
                    alu_v1_q  <= v1_q[issue_idx];
                    alu_v2_q  <= v2_q[issue_idx];
                    alu_imm_q <= imm_q[issue_idx];
                    alu_pc_q  <= pc_q[issue_idx];
                    alu_rob_q <= rob_q[issue_idx];
                end
                if (do_dispatch) begin
                    valid_q[alloc_idx] <= 1'b1;
                    op_q[alloc_idx]    <= in_decode_op;
                    v1_q[alloc_idx]    <= dk1[DATA_W] ? dk1[DATA_W-1:0] : in_decode_value1;
                    v2_q[alloc_idx]    <= dk2[DATA_W] ? dk2[DATA_W-1:0] : in_decode_value2;
                    t1_q[alloc_idx]    <= dk1[DATA_W] ? TAG_NONE : in_decode_tag1;
                    t2_q[alloc_idx]    <= dk2[DATA_W] ? TAG_NONE : in_decode_tag2;
                    imm_q[alloc_idx]   <= in_decode_imm;
                    pc_q[alloc_idx]    <= in_decode_pc;
                    rob_q[alloc_idx]   <= in_decode_rob_tag;
                    age_q[alloc_idx]   <= '0;
                    for (int j = 0; j < RS_DEPTH; j++) begin
                        if (j != int'(alloc_idx)) age_q[j][alloc_idx] <= valid_q[j];
                    end
                end
                count_q <= count_q + CNT_W'(do_dispatch) - CNT_W'(do_issue);
            end
        end
    end

    assign out_fetcher_isidle = has_free;
    assign out_rs_count       = count_q;
    assign out_alu_op         = alu_op_q;
    assign out_alu_value1     = alu_v1_q;
    assign out_alu_value2     = alu_v2_q;
    assign out_alu_imm        = alu_imm_q;
    assign out_alu_pc         = alu_pc_q;
    assign out_alu_rob_tag    = alu_rob_q;

endmodule

// File: tb/tb_rs_age_multi_cdb.sv
// tb/tb_rs_age_multi_cdb.sv - directed self-checking bench for rs_age_multi_cdb
module tb_rs_age_multi_cdb;

    logic        clk;
    logic        rst, rdy, ce;
    logic [3:0]  rob_tag, tag1, tag2;
    logic [5:0]  op;
    logic [31:0] value1, value2, imm, pc;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_value;
    logic        alu_ready, misbranch;
    logic        isidle;
    logic [4:0]  count;
    logic [5:0]  alu_op;
    logic [31:0] alu_v1, alu_v2, alu_imm, alu_pc;
    logic [3:0]  alu_rob;

    int tests_run = 0;
    int tests_failed = 0;

    rs_age_multi_cdb dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_fetcher_ce(ce), .in_decode_rob_tag(rob_tag), .in_decode_op(op),
        .in_decode_value1(value1), .in_decode_value2(value2),
        .in_decode_tag1(tag1), .in_decode_tag2(tag2),
        .in_decode_imm(imm), .in_decode_pc(pc),
        .in_cdb_tag(cdb_tag), .in_cdb_value(cdb_value),
        .in_alu_ready(alu_ready), .in_rob_misbranch(misbranch),
        .out_fetcher_isidle(isidle), .out_rs_count(count),
        .out_alu_op(alu_op), .out_alu_value1(alu_v1), .out_alu_value2(alu_v2),
        .out_alu_imm(alu_imm), .out_alu_pc(alu_pc), .out_alu_rob_tag(alu_rob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_dispatch(input logic [3:0] rt, input logic [5:0] o,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] ta, input logic [3:0] tb);
        ce = 1'b1; rob_tag = rt; op = o; value1 = a; value2 = b;
        tag1 = ta; tag2 = tb; imm = {24'h0, 2'b0, o}; pc = {28'h0, rt} << 2;
    endtask

    task automatic idle_inputs();
        ce = 1'b0; rob_tag = 4'd0; op = 6'd0; value1 = '0; value2 = '0;
        tag1 = 4'd0; tag2 = 4'd0; imm = '0; pc = '0;
        cdb_tag = '0; cdb_value = '0; misbranch = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; alu_ready = 1'b1;
        idle_inputs();
        tick(); tick();
        tests_run++;
        if (alu_op !== 6'd0) begin tests_failed++; $display("FAIL reset_op got %0d want 0", alu_op); end
        tests_run++;
        if (count !== 5'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", count); end
        tests_run++;
        if (isidle !== 1'b1) begin tests_failed++; $display("FAIL reset_isidle got %0b want 1", isidle); end
        tests_run++;
        if (alu_rob !== 4'd0 || alu_v1 !== 32'd0) begin
            tests_failed++; $display("FAIL reset_outs rob=%0d v1=%0h want 0/0", alu_rob, alu_v1);
        end
        rst = 1'b1;
    endtask

    task automatic test_ready_dispatch();
        drive_dispatch(4'd5, 6'd1, 32'd3, 32'd4, 4'd0, 4'd0);
        tick();
        idle_inputs();
        tests_run++;
        if (count !== 5'd1 || alu_op !== 6'd0) begin
            tests_failed++; $display("FAIL rd_after_dispatch count=%0d op=%0d want 1/0", count, alu_op);
        end
        tick();
        tests_run++;
        if (alu_op !== 6'd1 || alu_rob !== 4'd5 || alu_v1 !== 32'd3 || alu_v2 !== 32'd4 || count !== 5'd0) begin
            tests_failed++;
            $display("FAIL rd_issue op=%0d rob=%0d v1=%0d v2=%0d cnt=%0d want 1/5/3/4/0", alu_op, alu_rob, alu_v1, alu_v2, count);
        end
        rdy = 1'b0;
        tick();
        tests_run++;
        if (alu_op !== 6'd1) begin tests_failed++; $display("FAIL rdy_hold op=%0d want 1", alu_op); end
        rdy = 1'b1;
        tick();
        tests_run++;
        if (alu_op !== 6'd0 || alu_rob !== 4'd5) begin
            tests_failed++; $display("FAIL issue_pulse op=%0d rob=%0d want 0/5", alu_op, alu_rob);
        end
    endtask

    task automatic test_wakeup_bypass();
        drive_dispatch(4'd2, 6'd2, 32'hdead, 32'hbeef, 4'd7, 4'd9);
        cdb_tag = {4'd0, 4'd7}; cdb_value = {32'h0, 32'h11};
        tick();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if (alu_op !== 6'd0) begin tests_failed++; $display("FAIL wake_early_issue cycle %0d op=%0d want 0", i, alu_op); end
        end
        cdb_tag = {4'd9, 4'd9}; cdb_value = {32'h33, 32'h22};
        tick();
        idle_inputs();
        tests_run++;
        if (alu_op !== 6'd0) begin tests_failed++; $display("FAIL wake_same_edge op=%0d want 0", alu_op); end
        tick();
        tests_run++;
        if (alu_op !== 6'd2 || alu_rob !== 4'd2 || alu_v1 !== 32'h11 || alu_v2 !== 32'h22) begin
            tests_failed++;
            $display("FAIL wake_issue op=%0d rob=%0d v1=%0h v2=%0h want 2/2/11/22", alu_op, alu_rob, alu_v1, alu_v2);
        end
    endtask

    task automatic test_age_order();
        logic [3:0] exp_rob [3];
        // All three eligible together: the oldest (A) goes first.
        alu_ready = 1'b0;
        drive_dispatch(4'd10, 6'd3, 32'd0, 32'd1, 4'd3, 4'd0); tick();
        drive_dispatch(4'd11, 6'd4, 32'd2, 32'd3, 4'd0, 4'd0); tick();
        drive_dispatch(4'd12, 6'd5, 32'd4, 32'd5, 4'd0, 4'd0); tick();
        idle_inputs();
        cdb_tag = {4'd0, 4'd3}; cdb_value = {32'h0, 32'h33};
        tick();
        idle_inputs();
        alu_ready = 1'b1;
        exp_rob[0] = 4'd10; exp_rob[1] = 4'd11; exp_rob[2] = 4'd12;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (alu_rob !== exp_rob[i] || alu_op === 6'd0) begin
                tests_failed++; $display("FAIL age_together[%0d] rob=%0d op=%0d want rob %0d", i, alu_rob, alu_op, exp_rob[i]);
            end
        end
        tests_run++;
        if (alu_v1 !== 32'd4) begin tests_failed++; $display("FAIL age_together_v1 got %0h want 4", alu_v1); end
        tick();
        // A wakes late: B and C issue first.
        drive_dispatch(4'd13, 6'd6, 32'd0, 32'd1, 4'd3, 4'd0); tick();
        drive_dispatch(4'd14, 6'd7, 32'd0, 32'd1, 4'd0, 4'd0); tick();
        tests_run++;
        if (alu_op !== 6'd0) begin tests_failed++; $display("FAIL age_late_none op=%0d want 0", alu_op); end
        drive_dispatch(4'd15, 6'd8, 32'd0, 32'd1, 4'd0, 4'd0); tick();
        idle_inputs();
        tests_run++;
        if (alu_rob !== 4'd14 || alu_op !== 6'd7) begin tests_failed++; $display("FAIL age_late_b rob=%0d op=%0d want 14/7", alu_rob, alu_op); end
        tick();
        tests_run++;
        if (alu_rob !== 4'd15 || alu_op !== 6'd8) begin tests_failed++; $display("FAIL age_late_c rob=%0d op=%0d want 15/8", alu_rob, alu_op); end
        cdb_tag = {4'd3, 4'd0}; cdb_value = {32'h44, 32'h0};
        tick();
        idle_inputs();
        tests_run++;
        if (alu_op !== 6'd0) begin tests_failed++; $display("FAIL age_late_gap op=%0d want 0", alu_op); end
        tick();
        tests_run++;
        if (alu_rob !== 4'd13 || alu_op !== 6'd6 || alu_v1 !== 32'h44) begin
            tests_failed++; $display("FAIL age_late_a rob=%0d op=%0d v1=%0h want 13/6/44", alu_rob, alu_op, alu_v1);
        end
    endtask

    task automatic test_full_backpressure();
        alu_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_dispatch(4'((i % 15) + 1), 6'(i + 1), 32'(i), 32'(i * 2), 4'd0, 4'd0);
            tick();
        end
        idle_inputs();
        tests_run++;
        if (isidle !== 1'b0 || count !== 5'd16) begin
            tests_failed++; $display("FAIL full_state isidle=%0b count=%0d want 0/16", isidle, count);
        end
        drive_dispatch(4'd9, 6'h3f, 32'd99, 32'd99, 4'd0, 4'd0);
        tick();
        idle_inputs();
        tests_run++;
        if (count !== 5'd16 || alu_op !== 6'd0) begin
            tests_failed++; $display("FAIL full_drop count=%0d op=%0d want 16/0", count, alu_op);
        end
        alu_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            tests_run++;
            if (alu_op !== 6'(i + 1) || alu_v1 !== 32'(i) || count !== 5'(15 - i)) begin
                tests_failed++;
                $display("FAIL drain[%0d] op=%0d v1=%0d cnt=%0d want %0d/%0d/%0d", i, alu_op, alu_v1, count, i + 1, i, 15 - i);
            end
        end
        tick();
        tests_run++;
        if (alu_op !== 6'd0 || isidle !== 1'b1) begin
            tests_failed++; $display("FAIL drain_end op=%0d isidle=%0b want 0/1", alu_op, isidle);
        end
    endtask

    task automatic test_flush();
        alu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_dispatch(4'(i + 1), 6'(i + 20), 32'(i), 32'(i), 4'd0, 4'd0);
            tick();
        end
        idle_inputs();
        tests_run++;
        if (count !== 5'd3) begin tests_failed++; $display("FAIL flush_pre count=%0d want 3", count); end
        alu_ready = 1'b1;
        drive_dispatch(4'd6, 6'd30, 32'd1, 32'd1, 4'd0, 4'd0);
        misbranch = 1'b1;
        tick();
        idle_inputs();
        tests_run++;
        if (count !== 5'd0 || alu_op !== 6'd0) begin
            tests_failed++; $display("FAIL flush count=%0d op=%0d want 0/0", count, alu_op);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (alu_op !== 6'd0 || count !== 5'd0) begin
                tests_failed++; $display("FAIL flush_ghost[%0d] op=%0d cnt=%0d want 0/0", i, alu_op, count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ready_dispatch();
        test_wakeup_bypass();
        test_age_order();
        test_full_backpressure();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
